// File: rtl/sccb_phase3_writer.sv
// SCCB three-phase write master: START, device address, register address, data, STOP.
// One write per edge of the toggle-type send input; ACK slots are driven high and never sampled.
module sccb_phase3_writer #(
    parameter int unsigned CLK_DIV  = 125,
    parameter logic [7:0]  DEV_ADDR = 8'h34
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] address,
    input  logic [7:0] value,
    output logic       SCL,
    output logic       SDA,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, BIT, STOP} state_t;

    state_t      state, state_nx;
    logic        send_q;
    logic        request;
    logic [15:0] div_cnt;
    logic        tick;
    logic [1:0]  quarter;
    logic [3:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [7:0]  addr_q;
    logic [7:0]  value_q;
    logic [7:0]  cur_byte;
    logic [2:0]  bit_idx;
    logic        last_quarter;

    // No reset here: send_q follows send on every edge, so releasing rst_n never looks like a toggle.
    always_ff @(posedge clk) begin
        send_q <= send;
    end

    assign request      = (send != send_q);
    assign tick         = (div_cnt == 16'(CLK_DIV - 1));
    assign last_quarter = tick && (quarter == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            quarter  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            addr_q   <= '0;
            value_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                div_cnt  <= '0;
                quarter  <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                if (request) begin
                    addr_q  <= address;
                    value_q <= value;
                end
            end else if (tick) begin
                div_cnt <= '0;
                quarter <= quarter + 2'd1;
                if (state == BIT && quarter == 2'd3) begin
                    if (bit_cnt == 4'd8) begin
                        bit_cnt  <= '0;
                        byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (request) state_nx = START;
            START: if (last_quarter) state_nx = BIT;
            BIT:   if (last_quarter && bit_cnt == 4'd8 && byte_cnt == 2'd2) state_nx = STOP;
            STOP:  if (last_quarter) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        case (byte_cnt)
            2'd0:    cur_byte = DEV_ADDR;
            2'd1:    cur_byte = addr_q;
            default: cur_byte = value_q;
        endcase
        bit_idx = 3'd7 - bit_cnt[2:0];
    end

    // Outputs decode straight from registered state, so SDA moves exactly when a bit's Q0 begins.
    always_comb begin
        SCL  = 1'b1;
        SDA  = 1'b1;
        busy = 1'b1;
        case (state)
            IDLE: busy = 1'b0;
            START: SDA = ~quarter[1];
            BIT: begin
                SCL = quarter[1];
                SDA = (bit_cnt == 4'd8) ? 1'b1 : cur_byte[bit_idx];
            end
            STOP: begin
                SCL = quarter[1];
                SDA = (quarter == 2'd3);
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_sccb_phase3_writer.sv
// Bench for sccb_phase3_writer: per-cycle waveform model, on-wire byte decoder and protocol checks.
module tb_sccb_phase3_writer;

    localparam int CD    = 4;
    localparam int TOTAL = 116 * CD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send = 1'b0;
    logic [7:0] address = '0;
    logic [7:0] value = '0;
    logic       SCL, SDA, busy;

    int vectors = 0;
    int miscompares = 0;

    sccb_phase3_writer #(.CLK_DIV(CD), .DEV_ADDR(8'h34)) dut (
        .clk(clk), .rst_n(rst_n), .send(send), .address(address), .value(value),
        .SCL(SCL), .SDA(SDA), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the 116-quarter frame, bytes captured at acceptance.
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic       m_send_q = 1'b0;
    logic [7:0] m_bytes [3];

    function automatic logic [1:0] wave(input int pos);
        int q;
        int b;
        int k;
        int qq;
        logic [7:0] by;
        q = pos / CD;
        if (q < 4) return {1'b1, logic'(q < 2)};
        if (q < 112) begin
            b  = (q - 4) / 4;
            qq = (q - 4) % 4;
            k  = b % 9;
            by = m_bytes[b / 9];
            return {logic'(qq >= 2), (k == 8) ? 1'b1 : by[7 - k]};
        end
        qq = q - 112;
        return {logic'(qq >= 2), logic'(qq == 3)};
    endfunction

    always @(posedge clk) begin
        logic req;
        if (!rst_n) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_send_q = send;
        end else begin
            req      = (send != m_send_q);
            m_send_q = send;
            if (m_active) begin
                if (m_pos == TOTAL - 1) m_active = 1'b0;
                else m_pos++;
            end else if (req) begin
                m_active   = 1'b1;
                m_pos      = 0;
                m_bytes[0] = 8'h34;
                m_bytes[1] = address;
                m_bytes[2] = value;
            end
        end
    end

    // Compare, decode and protocol tracking, all on the falling edge.
    logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_busy = 1'b0;
    logic       bits [$];
    int         busy_len = 0, n_start = 0, n_stop = 0, done_cnt = 0;
    logic [7:0] last_b [3];
    int         last_len = 0;

    always @(negedge clk) begin
        logic [1:0] e;
        logic [7:0] d;
        e = (!rst_n || !m_active) ? 2'b11 : wave(m_pos);
        chk("scl", 32'(SCL), 32'(e[1]));
        chk("sda", 32'(SDA), 32'(e[0]));
        chk("busy", 32'(busy), 32'(rst_n && m_active));
        if (!rst_n) begin
            bits.delete();
            busy_len = 0; n_start = 0; n_stop = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                busy_len++;
                if (!prev_scl && SCL) bits.push_back(SDA);
                if (prev_scl && SCL && prev_sda && !SDA) n_start++;
                if (prev_scl && SCL && !prev_sda && SDA) n_stop++;
            end
            if (prev_busy && !busy) begin
                chk("rise_count", 32'(bits.size()), 32'd28);
                chk("start_cond", 32'(n_start), 32'd1);
                chk("stop_cond", 32'(n_stop), 32'd1);
                if (bits.size() == 28) begin
                    for (int by = 0; by < 3; by++) begin
                        for (int i = 0; i < 8; i++) d[7 - i] = bits[by * 9 + i];
                        last_b[by] = d;
                        chk("byte_vs_model", 32'(d), 32'(m_bytes[by]));
                        chk("ack_slot", 32'(bits[by * 9 + 8]), 32'd1);
                    end
                end
                last_len = busy_len;
                chk("busy_len_vs_model", 32'(busy_len), 32'(TOTAL));
                done_cnt++;
                bits.delete();
                busy_len = 0; n_start = 0; n_stop = 0;
            end
            prev_busy = busy;
        end
        prev_scl = SCL;
        prev_sda = SDA;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int limit);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < limit) begin
            step();
            n++;
        end
        chk("done_timeout", 32'(done_cnt != start), 32'd1);
    endtask

    task automatic frame_lit(input logic [7:0] b1, input logic [7:0] b2);
        chk("lit_byte0", 32'(last_b[0]), 32'h34);
        chk("lit_byte1", 32'(last_b[1]), 32'(b1));
        chk("lit_byte2", 32'(last_b[2]), 32'(b2));
        chk("lit_busy_len", 32'(last_len), 32'd464);
    endtask

    initial begin
        int d0;
        int seen;
        repeat (3) step();
        chk("rst_scl", 32'(SCL), 32'd1);
        chk("rst_sda", 32'(SDA), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        send = 1'b1;
        step();
        rst_n = 1'b1;
        repeat (5) step();
        chk("no_req_on_release", 32'(busy), 32'd0);

        // send 1->0, then 0->1: both edges request
        address = 8'h0C; value = 8'h5A;
        send = ~send;
        step();
        chk("busy_next_cycle", 32'(busy), 32'd1);
        wait_done(TOTAL + 20);
        frame_lit(8'h0C, 8'h5A);

        address = 8'h1E; value = 8'h00;
        send = ~send;
        wait_done(TOTAL + 20);
        frame_lit(8'h1E, 8'h00);

        // second toggle while busy is dropped
        address = 8'h81; value = 8'h7E;
        d0 = done_cnt;
        send = ~send;
        repeat (100) step();
        send = ~send;
        wait_done(TOTAL + 20);
        seen = 0;
        repeat (600) begin
            step();
            if (busy) seen++;
        end
        chk("no_second_xfer", 32'(seen), 32'd0);
        chk("single_fall", 32'(done_cnt - d0), 32'd1);
        frame_lit(8'h81, 8'h7E);

        // reset mid-transfer
        d0 = done_cnt;
        send = ~send;
        repeat (200) step();
        rst_n = 1'b0;
        #1;
        chk("abort_scl", 32'(SCL), 32'd1);
        chk("abort_sda", 32'(SDA), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("abort_no_frame", 32'(done_cnt - d0), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        address = 8'hC3; value = 8'h96;
        send = ~send;
        wait_done(TOTAL + 20);
        frame_lit(8'hC3, 8'h96);

        // inputs changed mid-transfer do not reach the wire
        address = 8'hA5; value = 8'h3C;
        send = ~send;
        repeat (50) step();
        address = 8'hFF; value = 8'h00;
        wait_done(TOTAL + 20);
        frame_lit(8'hA5, 8'h3C);

        // toggle in the cycle busy falls is accepted; busy low exactly one cycle
        address = 8'h55; value = 8'hAA;
        send = ~send;
        step();
        seen = 0;
        while (busy && seen < TOTAL + 20) begin
            step();
            seen++;
        end
        chk("fall_seen", 32'(busy), 32'd0);
        address = 8'h12; value = 8'h34;
        send = ~send;
        step();
        chk("back_to_back_busy", 32'(busy), 32'd1);
        chk("prev_frame_byte1", 32'(last_b[1]), 32'h55);
        wait_done(TOTAL + 20);
        frame_lit(8'h12, 8'h34);

        repeat (10) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
